// File: rtl/product_accumulator.sv
// Accumulates LEN signed products into a saturating ACC_W-bit sum, then holds
// the result under a valid/ready handshake until downstream consumes it.
module product_accumulator #(
    parameter int N     = 4,
    parameter int ACC_W = 12,
    parameter int LEN   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [2*N-1:0]   product,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    clear,
    output logic signed [ACC_W-1:0] acc_out,
    output logic                    sat,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
    localparam int SUM_W = ACC_W + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);
    localparam logic signed [ACC_W-1:0] MAX_POS = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_NEG = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic {
        ACC,
        DONE
    } state_t;

    state_t                    state_q, state_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic        [CNT_W-1:0]   cnt_q, cnt_d;
    logic                      sat_q, sat_d;
    logic signed [SUM_W-1:0]   sumWide;
    logic                      overflow;

    // One guard bit above the accumulator: overflow shows as the top two bits differing.
    assign sumWide  = SUM_W'(acc_q) + SUM_W'(product);
    assign overflow = sumWide[SUM_W-1] != sumWide[SUM_W-2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACC;
            acc_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        // clear wins over both the accept and the output handshake.
        if (clear) begin
            state_d = ACC;
            acc_d   = '0;
            cnt_d   = '0;
            sat_d   = 1'b0;
        end else begin
            unique case (state_q)
                ACC: begin
                    if (in_valid) begin
                        if (overflow) begin
                            acc_d = sumWide[SUM_W-1] ? MIN_NEG : MAX_POS;
                            sat_d = 1'b1;
                        end else begin
                            acc_d = sumWide[ACC_W-1:0];
                        end
                        if (cnt_q == LAST_CNT) begin
                            state_d = DONE;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = ACC;
                        acc_d   = '0;
                        cnt_d   = '0;
                        sat_d   = 1'b0;
                    end
                end
                default: state_d = ACC;
            endcase
        end
    end

    assign in_ready  = (state_q == ACC);
    assign out_valid = (state_q == DONE);
    assign acc_out   = acc_q;
    assign sat       = sat_q;

endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 Parameter N, default 4: operand width of the upstream signed multiplier; product width is 2*N.
REQ-002 Parameter ACC_W, default 12: signed accumulator width; ACC_W SHALL be >= 2*N.
REQ-003 Parameter LEN, default 4: number of products summed per result; LEN SHALL be >= 1.
REQ-004 Port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous and active-high.
REQ-006 Port product, input, 2*N, signed: product word from the upstream multiplier.
REQ-007 Port in_valid, input, 1: product is valid this cycle.
REQ-008 Port in_ready, output, 1: block accepts product this cycle.
REQ-009 Port clear, input, 1: synchronous abort of the current accumulation.
REQ-010 Port acc_out, output, ACC_W, signed: accumulated result.
REQ-011 Port sat, output, 1: at least one saturation event occurred in the current result.
REQ-012 Port out_valid, output, 1: acc_out and sat are valid.
REQ-013 Port out_ready, input, 1: downstream consumes the result.

Function
REQ-014 The block SHALL implement two states: ACC (collecting products) and DONE (holding result).
REQ-015 In ACC, in_ready SHALL be 1 and out_valid 0; in DONE, in_ready SHALL be 0 and out_valid 1.
REQ-016 A product SHALL be accepted only on a cycle with in_valid=1 and in_ready=1.
REQ-017 Each accepted product SHALL be sign-extended to ACC_W bits and added to the accumulator.
REQ-018 On signed overflow, the accumulator SHALL saturate: positive overflow gives 2^(ACC_W-1)-1, negative overflow gives -2^(ACC_W-1).
REQ-019 When a saturation occurs, sat SHALL be set and SHALL stay set (sticky) until the result is consumed or cleared.
REQ-020 An internal counter SHALL count accepted products from 0 to LEN-1.
REQ-021 On the LEN-th accept, the state SHALL go to DONE; out_valid SHALL assert the next cycle with acc_out including that product.
REQ-022 In DONE, acc_out and sat SHALL hold stable until out_valid=1 and out_ready=1.
REQ-023 On the DONE handshake cycle, the block SHALL zero the accumulator, counter and sat and return to ACC; in_ready SHALL be 1 the following cycle.
REQ-024 A result SHALL NOT be accepted from upstream and handed downstream in the same cycle; there is no bypass.
REQ-025 clear=1 SHALL zero the accumulator, counter and sat and force ACC on the next edge, in either state.
REQ-026 clear SHALL take priority over a simultaneous accept or output handshake; the product presented that cycle is discarded.
REQ-027 In ACC, acc_out SHALL show the running partial sum and sat the running flag, with out_valid=0.
REQ-028 With LEN=1, every accepted product SHALL produce a result.
REQ-029 Counter width SHALL be clog2(LEN) bits, with a minimum of 1; the counter SHALL NOT wrap before the transition to DONE.

Reset
REQ-030 While rst=1, regardless of clk, the state SHALL be ACC and the accumulator, counter and sat SHALL be 0.
REQ-031 During reset, out_valid SHALL be 0 and acc_out 0; in_ready SHALL be 1 from the first edge after rst deasserts.
REQ-032 Asserting rst mid-accumulation or in DONE SHALL discard the partial or held result immediately.

Verification
REQ-033 Defaults, products 49,49,49,49 with in_valid held high -> out_valid=1 the cycle after the 4th accept, acc_out=196, sat=0.
REQ-034 ACC_W=8, products 49 x4 -> acc_out=127, sat=1; products -56 x4 -> acc_out=-128, sat=1.
REQ-035 Result in DONE with out_ready=0 for 5 cycles, then 1 -> acc_out stable and in_ready=0 throughout; in_ready=1 and acc_out=0 the cycle after the handshake.
REQ-036 Products 10,-3 accepted, then clear=1 coincident with in_valid=1, product=20 -> the next 4 products 1,2,3,4 yield acc_out=10.
REQ-037 rst pulsed asynchronously between clock edges after 2 accepts -> outputs are 0 immediately; the next 4 accepts of 5 yield 20.
REQ-038 in_valid toggled randomly, products -8..7 x -8..7, compared against a saturating reference sum -> acc_out and sat match for every result.
